// File: rtl/gated_seq_approx_multiplier_if.sv
// ---------------------------------------------------------------------------
// gated_seq_approx_multiplier_if
//
// Bundles the operand/product handshake and status signals of the
// gated sequential approximate multiplier.
//
// Signals:
//   in_valid  : operand pair valid (master -> slave)
//   in_ready  : block can accept operands (slave -> master)
//   a, b      : multiplicand / multiplier, unsigned, N bits (master -> slave)
//   out_valid : product valid (slave -> master)
//   out_ready : consumer accepts product (master -> slave)
//   product   : 2N-bit result (slave -> master)
//   gate_en   : clock-gating enable for the product register (slave -> master)
//   busy      : high while an operation is in flight or held (slave -> master)
//
// Handshake rule: a transfer happens on a rising clock edge where valid and
// ready are both high. A producer holds valid and data stable until that edge.
// ---------------------------------------------------------------------------
interface gated_seq_approx_multiplier_if #(
    parameter int N = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [N-1:0]     a;
    logic [N-1:0]     b;
    logic             out_valid;
    logic             out_ready;
    logic [2*N-1:0]   product;
    logic             gate_en;
    logic             busy;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, product, gate_en, busy
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, product, gate_en, busy
    );
endinterface

// File: rtl/gated_seq_approx_multiplier.sv
// ---------------------------------------------------------------------------
// gated_seq_approx_multiplier
//
// Iterative unsigned shift-add multiplier. One multiplier bit is examined per
// CALC cycle; when that bit is set the shifted multiplicand is accumulated
// into the product register. The accumulation uses approximate columns for
// the low APPROX_LSB product bits (OR, no carry) and an exact add above them
// (carry-in 0 at column APPROX_LSB, carry out of the top column dropped).
// The operation ends as soon as the highest set multiplier bit has been
// processed, so small multipliers finish early.
//
// Ports:
//   clk       : system clock, rising edge
//   rst_n     : synchronous active-low reset
//   bus       : slave side of gated_seq_approx_multiplier_if
//               (in_valid/in_ready/a/b, out_valid/out_ready/product,
//                gate_en, busy)
//   state_dbg : current FSM state (IDLE=0, CALC=1, DONE=2)
//
// Parameters:
//   N          : operand width (N >= 2)
//   APPROX_LSB : number of low product columns combined approximately
//                (0 = exact, up to 2N)
// ---------------------------------------------------------------------------
module gated_seq_approx_multiplier #(
    parameter int N          = 8,
    parameter int APPROX_LSB = 0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    gated_seq_approx_multiplier_if.slave  bus,
    output logic [1:0]                    state_dbg
);

    localparam int W  = 2 * N;
    localparam int KW = (N > 1) ? $clog2(N) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // Columns below APPROX_LSB are OR-combined; the mask marks them.
    function automatic logic [W-1:0] approx_mask();
        logic [W-1:0] m;
        m = '0;
        for (int i = 0; i < W; i++) begin
            if (i < APPROX_LSB) begin
                m[i] = 1'b1;
            end
        end
        return m;
    endfunction

    localparam logic [W-1:0] LO_MASK = approx_mask();

    logic [1:0]    state;
    logic [N-1:0]  a_q;
    logic [N-1:0]  b_q;
    logic [KW-1:0] k;
    logic [W-1:0]  product_q;

    logic [W-1:0]  addend;
    logic [W-1:0]  sum_next;
    logic [N-1:0]  b_rest;
    logic          last_bit;
    logic          add_now;

    always_comb begin
        addend   = {{N{1'b0}}, a_q} << k;
        // Bits of b above k all zero means k is the highest set bit.
        b_rest   = b_q >> k;
        last_bit = (b_rest[N-1:1] == '0);
        add_now  = (state == S_CALC) && b_q[k];
        // Upper operands have their low columns cleared, so their sum has
        // no carry into or out of the approximate region; the top carry
        // falls off the W-bit result.
        sum_next = ((product_q | addend) & LO_MASK)
                 | ((product_q & ~LO_MASK) + (addend & ~LO_MASK));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            a_q       <= '0;
            b_q       <= '0;
            k         <= '0;
            product_q <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        a_q       <= bus.a;
                        b_q       <= bus.b;
                        product_q <= '0;
                        k         <= '0;
                        // A zero multiplier has nothing to accumulate.
                        state     <= (bus.b == '0) ? S_DONE : S_CALC;
                    end
                end
                S_CALC: begin
                    if (add_now) begin
                        product_q <= sum_next;
                    end
                    if (last_bit) begin
                        state <= S_DONE;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                S_DONE: begin
                    // No new acceptance on this edge; IDLE raises in_ready
                    // one cycle later.
                    if (bus.out_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = (state == S_IDLE);
    assign bus.out_valid = (state == S_DONE);
    assign bus.busy      = (state != S_IDLE);
    assign bus.gate_en   = add_now;
    assign bus.product   = product_q;
    assign state_dbg     = state;

endmodule

// File: tb/tb_gated_seq_approx_multiplier.sv
// ---------------------------------------------------------------------------
// tb_gated_seq_approx_multiplier
//
// Two instances run in lockstep on shared inputs: an exact one
// (APPROX_LSB=0) and an approximate one (APPROX_LSB=4). Expected products
// and gate_en pulse counts are queued when operands are sent and checked
// when each instance hands its product over.
// ---------------------------------------------------------------------------
module tb_gated_seq_approx_multiplier;

    localparam int N  = 8;
    localparam int AL = 4;

    logic clk;
    logic rst_n;
    logic [1:0] state_dbg0;
    logic [1:0] state_dbg1;

    gated_seq_approx_multiplier_if #(.N(N)) bus0 ();
    gated_seq_approx_multiplier_if #(.N(N)) bus1 ();

    assign bus1.in_valid  = bus0.in_valid;
    assign bus1.a         = bus0.a;
    assign bus1.b         = bus0.b;
    assign bus1.out_ready = bus0.out_ready;

    gated_seq_approx_multiplier #(.N(N), .APPROX_LSB(0)) dut_exact (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus0),
        .state_dbg (state_dbg0)
    );

    gated_seq_approx_multiplier #(.N(N), .APPROX_LSB(AL)) dut_approx (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus1),
        .state_dbg (state_dbg1)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // scoreboard state
    int n_vec = 0;
    int n_err = 0;
    logic [2*N-1:0] exp_q[$];
    logic [2*N-1:0] exp_aq[$];
    int             eg_q[$];
    int             g0 = 0;
    int             g1 = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: accumulate each partial product, OR in the low AL columns,
    // integer add of the upper parts.
    function automatic logic [2*N-1:0] model_mul(input logic [N-1:0] av,
                                                 input logic [N-1:0] bv,
                                                 input int l);
        logic [2*N-1:0] acc;
        logic [2*N-1:0] add;
        logic [2*N-1:0] lo;
        logic [31:0]    hi;
        acc = '0;
        for (int j = 0; j < N; j++) begin
            if (bv[j]) begin
                add = {{N{1'b0}}, av} << j;
                lo  = '0;
                for (int c = 0; c < l && c < 2*N; c++) lo[c] = acc[c] | add[c];
                if (l >= 2*N) hi = 0;
                else          hi = ((32'(acc) >> l) + (32'(add) >> l)) << l;
                acc = lo | hi[2*N-1:0];
            end
        end
        return acc;
    endfunction

    // monitor: count gate pulses, compare products on each handshake
    always @(negedge clk) begin
        logic [2*N-1:0] e;
        int eg;
        if (!rst_n) begin
            g0 = 0;
            g1 = 0;
        end else begin
            if (bus0.gate_en) g0++;
            if (bus1.gate_en) g1++;
            if (bus0.out_valid && bus0.out_ready) begin
                if (exp_q.size() == 0 || eg_q.size() == 0) begin
                    check("sb_exact_nonempty", 32'(exp_q.size()), 32'd1);
                end else begin
                    e  = exp_q.pop_front();
                    eg = eg_q[0];
                    check("product_exact", 32'(bus0.product), 32'(e));
                    check("gate_count_exact", 32'(g0), 32'(eg));
                end
                g0 = 0;
            end
            if (bus1.out_valid && bus1.out_ready) begin
                if (exp_aq.size() == 0 || eg_q.size() == 0) begin
                    check("sb_approx_nonempty", 32'(exp_aq.size()), 32'd1);
                end else begin
                    e  = exp_aq.pop_front();
                    eg = eg_q.pop_front();
                    check("product_approx", 32'(bus1.product), 32'(e));
                    check("gate_count_approx", 32'(g1), 32'(eg));
                end
                g1 = 0;
            end
        end
    end

    // driver tasks (all drives at 1 time unit after a rising edge)
    task automatic send(input logic [N-1:0] av, input logic [N-1:0] bv);
        int t;
        t = 0;
        bus0.a        = av;
        bus0.b        = bv;
        bus0.in_valid = 1'b1;
        while (!bus0.in_ready && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        check("accept_in_time", 32'(t < 200), 32'd1);
        exp_q.push_back(16'(av) * 16'(bv));
        exp_aq.push_back(model_mul(av, bv, AL));
        eg_q.push_back($countones(bv));
        @(posedge clk); #1;
    endtask

    task automatic wait_out(output int cyc);
        cyc = 0;
        while (!bus0.out_valid && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_in_ready0"},  32'(bus0.in_ready),  32'd1);
        check({tag, "_out_valid0"}, 32'(bus0.out_valid), 32'd0);
        check({tag, "_product0"},   32'(bus0.product),   32'd0);
        check({tag, "_gate_en0"},   32'(bus0.gate_en),   32'd0);
        check({tag, "_busy0"},      32'(bus0.busy),      32'd0);
        check({tag, "_state0"},     32'(state_dbg0),     32'd0);
        check({tag, "_in_ready1"},  32'(bus1.in_ready),  32'd1);
        check({tag, "_product1"},   32'(bus1.product),   32'd0);
        check({tag, "_state1"},     32'(state_dbg1),     32'd0);
    endtask

    // directed sequence
    initial begin
        int cyc;
        int t;
        logic [N-1:0] ra;
        logic [N-1:0] rb;

        rst_n          = 1'b0;
        bus0.in_valid  = 1'b0;
        bus0.a         = '0;
        bus0.b         = '0;
        bus0.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_reset_values("reset");

        // exact multiply 13*11, gate pattern per CALC cycle
        bus0.out_ready = 1'b1;
        send(8'd13, 8'd11);
        bus0.in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("gate_calc%0d", i), 32'(bus0.gate_en), 32'((8'd11 >> i) & 8'd1));
            check($sformatf("busy_calc%0d", i), 32'(bus0.busy), 32'd1);
            @(posedge clk); #1;
        end
        check("out_valid_after_4", 32'(bus0.out_valid), 32'd1);
        check("product_143", 32'(bus0.product), 32'h008F);
        check("in_ready_in_done", 32'(bus0.in_ready), 32'd0);
        @(posedge clk); #1;
        check("in_ready_after_hs", 32'(bus0.in_ready), 32'd1);
        check("out_valid_after_hs", 32'(bus0.out_valid), 32'd0);

        // corner operands
        send(8'hFF, 8'hFF);
        bus0.in_valid = 1'b0;
        wait_out(cyc);
        check("latency_ff", 32'(cyc), 32'd8);
        check("product_fe01", 32'(bus0.product), 32'hFE01);
        @(posedge clk); #1;

        send(8'h5A, 8'h00);
        bus0.in_valid = 1'b0;
        check("zero_b_done_at_once", 32'(bus0.out_valid), 32'd1);
        check("zero_b_product", 32'(bus0.product), 32'd0);
        @(posedge clk); #1;

        // approximate columns
        send(8'h0F, 8'h03);
        bus0.in_valid = 1'b0;
        wait_out(cyc);
        check("latency_03", 32'(cyc), 32'd2);
        check("approx_0f_03", 32'(bus1.product), 32'h001F);
        check("exact_0f_03", 32'(bus0.product), 32'h002D);
        @(posedge clk); #1;

        send(8'h01, 8'h80);
        bus0.in_valid = 1'b0;
        wait_out(cyc);
        check("latency_80", 32'(cyc), 32'd8);
        check("approx_01_80", 32'(bus1.product), 32'h0080);
        @(posedge clk); #1;

        // backpressure with in_valid pulses while busy
        bus0.out_ready = 1'b0;
        send(8'd3, 8'd5);
        bus0.in_valid = 1'b0;
        wait_out(cyc);
        check("bp_reached_done", 32'(bus0.out_valid), 32'd1);
        for (int i = 0; i < 6; i++) begin
            bus0.in_valid = (i % 2 == 0);
            bus0.a        = 8'(i * 37 + 1);
            bus0.b        = 8'(i * 53 + 7);
            @(posedge clk); #1;
            check($sformatf("bp_out_valid%0d", i), 32'(bus0.out_valid), 32'd1);
            check($sformatf("bp_product%0d", i), 32'(bus0.product), 32'd15);
            check($sformatf("bp_in_ready%0d", i), 32'(bus0.in_ready), 32'd0);
        end
        bus0.in_valid  = 1'b0;
        bus0.out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release_in_ready", 32'(bus0.in_ready), 32'd1);

        // reset in the middle of CALC (k=3)
        send(8'hFF, 8'hFF);
        bus0.in_valid = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        check("midrst_in_calc", 32'(state_dbg0), 32'd1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        exp_q.delete();
        exp_aq.delete();
        eg_q.delete();
        check_reset_values("midrst");
        send(8'd2, 8'd2);
        bus0.in_valid = 1'b0;
        wait_out(cyc);
        check("after_rst_product", 32'(bus0.product), 32'd4);
        @(posedge clk); #1;

        // back-to-back random pairs, in_valid held high
        for (int i = 0; i < 20; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            send(ra, rb);
        end
        bus0.in_valid = 1'b0;
        t = 0;
        while ((exp_q.size() != 0 || exp_aq.size() != 0) && t < 2000) begin
            @(posedge clk); #1;
            t++;
        end
        check("drain_exact", 32'(exp_q.size()), 32'd0);
        check("drain_approx", 32'(exp_aq.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
